// File: rtl/ahb_lite_bus_arbiter.sv
// ahb_lite_bus_arbiter
// Two-master AHB-Lite arbiter placed in front of the system decoder/mux.
// M0 is the Cortex-M0 and M1 is the secondary master (DMA/test).
// Ownership moves only when the owner is idle and unlocked while the other master requests.
// The bus then spends one arbitration cycle driving IDLE before the new owner appears.
// The non-owning master is stalled through its own HREADY while it requests.
// Optional feature: define AHB_ARB_RR_EN for a round-robin tie-break in arbitration.
// Without it, ties go to HIGH_PRI.
module ahb_lite_bus_arbiter #(
    parameter logic DEFAULT_MASTER = 1'b0,
    parameter logic HIGH_PRI       = 1'b0
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    // master 0 (Cortex-M0)
    input  logic [31:0] HADDR_M0,
    input  logic [1:0]  HTRANS_M0,
    input  logic        HWRITE_M0,
    input  logic [2:0]  HSIZE_M0,
    input  logic [2:0]  HBURST_M0,
    input  logic [3:0]  HPROT_M0,
    input  logic        HMASTLOCK_M0,
    input  logic [31:0] HWDATA_M0,
    output logic [31:0] HRDATA_M0,
    output logic        HREADY_M0,
    output logic        HRESP_M0,
    // master 1 (DMA / test)
    input  logic [31:0] HADDR_M1,
    input  logic [1:0]  HTRANS_M1,
    input  logic        HWRITE_M1,
    input  logic [2:0]  HSIZE_M1,
    input  logic [2:0]  HBURST_M1,
    input  logic [3:0]  HPROT_M1,
    input  logic        HMASTLOCK_M1,
    input  logic [31:0] HWDATA_M1,
    output logic [31:0] HRDATA_M1,
    output logic        HREADY_M1,
    output logic        HRESP_M1,
    // shared bus
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic        HMASTLOCK,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP,
    output logic        HMASTER
);

    // Bit 0 of the OWN encodings is the owning master, which keeps the address select trivial.
    localparam logic [1:0] ST_OWN0  = 2'b00;
    localparam logic [1:0] ST_OWN1  = 2'b01;
    localparam logic [1:0] ST_ARB   = 2'b10;
    localparam logic [1:0] ST_RESET = DEFAULT_MASTER ? ST_OWN1 : ST_OWN0;

    logic [1:0]  state_q, state_d;
    logic        last_q, last_d;      // most recent owner; drives the bus during ARB
    logic        downer_q, downer_d;  // owner of the current data phase
    logic        dact_q, dact_d;      // current data phase belongs to a real transfer

    // Per-master views of the inputs, indexed by master number.
    logic [31:0] haddr_m  [2];
    logic [1:0]  htrans_m [2];
    logic [2:0]  hsize_m  [2];
    logic [2:0]  hburst_m [2];
    logic [3:0]  hprot_m  [2];
    logic [31:0] hwdata_m [2];
    logic [1:0]  hwrite_m;
    logic [1:0]  hmastlock_m;

    logic [1:0]  req;
    logic [1:0]  hready_m;
    logic [1:0]  hresp_m;
    logic        in_arb;
    logic        sel;
    logic        tie_winner;
    logic        winner;

    assign haddr_m[0]  = HADDR_M0;
    assign haddr_m[1]  = HADDR_M1;
    assign htrans_m[0] = HTRANS_M0;
    assign htrans_m[1] = HTRANS_M1;
    assign hsize_m[0]  = HSIZE_M0;
    assign hsize_m[1]  = HSIZE_M1;
    assign hburst_m[0] = HBURST_M0;
    assign hburst_m[1] = HBURST_M1;
    assign hprot_m[0]  = HPROT_M0;
    assign hprot_m[1]  = HPROT_M1;
    assign hwdata_m[0] = HWDATA_M0;
    assign hwdata_m[1] = HWDATA_M1;
    assign hwrite_m    = {HWRITE_M1, HWRITE_M0};
    assign hmastlock_m = {HMASTLOCK_M1, HMASTLOCK_M0};

    assign in_arb = (state_q == ST_ARB);
    // During ARB the bus keeps presenting the last owner's signals (with HTRANS forced to IDLE).
    assign sel     = in_arb ? last_q : state_q[0];
    assign HMASTER = sel;

    // Per-master request, stall and response gating.
    for (genvar gi = 0; gi < 2; gi++) begin : g_master
        localparam logic ID = (gi == 1);
        assign req[gi]      = htrans_m[gi][1];
        // The address owner sees the real bus ready.
        // Any other master is stalled only while it requests, so its address is held.
        assign hready_m[gi] = (!in_arb && (sel == ID)) ? HREADY : ~req[gi];
        // A master with no active data phase on the bus cannot be the target of a response.
        assign hresp_m[gi]  = (dact_q && (downer_q == ID)) ? HRESP : 1'b0;
    end

    assign HREADY_M0 = hready_m[0];
    assign HREADY_M1 = hready_m[1];
    assign HRESP_M0  = hresp_m[0];
    assign HRESP_M1  = hresp_m[1];
    assign HRDATA_M0 = HRDATA;
    assign HRDATA_M1 = HRDATA;
    assign HWDATA    = hwdata_m[downer_q];

`ifdef AHB_ARB_RR_EN
    // Round robin: a tie goes to whichever master did not own the bus last.
    assign tie_winner = ~last_q;
`else
    // Fixed priority: a tie always goes to HIGH_PRI.
    assign tie_winner = HIGH_PRI;
`endif

    // Address-phase mux; HTRANS is forced IDLE while arbitrating or held in reset.
    always_comb begin
        HADDR     = haddr_m[sel];
        HWRITE    = hwrite_m[sel];
        HSIZE     = hsize_m[sel];
        HBURST    = hburst_m[sel];
        HPROT     = hprot_m[sel];
        HMASTLOCK = hmastlock_m[sel];
        HTRANS    = (in_arb || !HRESETn) ? 2'b00 : htrans_m[sel];
    end

    // Ownership FSM and data-phase tracking; everything is frozen during wait states.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        downer_d = downer_q;
        dact_d   = dact_q;

        if (req[0] && req[1]) begin
            winner = tie_winner;
        end else if (req[0]) begin
            winner = 1'b0;
        end else if (req[1]) begin
            winner = 1'b1;
        end else begin
            winner = last_q;
        end

        case (state_q)
            ST_OWN0, ST_OWN1: begin
                // Release only at an idle, unlocked point while the other master waits.
                if (HREADY && !req[sel] && !hmastlock_m[sel] && req[~sel]) begin
                    state_d = ST_ARB;
                end
            end
            ST_ARB: begin
                if (HREADY) begin
                    state_d = winner ? ST_OWN1 : ST_OWN0;
                    last_d  = winner;
                end
            end
            default: begin
                state_d = ST_RESET;
                last_d  = DEFAULT_MASTER;
            end
        endcase

        if (HREADY) begin
            downer_d = sel;
            dact_d   = in_arb ? 1'b0 : htrans_m[sel][1];
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q  <= ST_RESET;
            last_q   <= DEFAULT_MASTER;
            downer_q <= DEFAULT_MASTER;
            dact_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            downer_q <= downer_d;
            dact_q   <= dact_d;
        end
    end

endmodule

// File: tb/tb_ahb_lite_bus_arbiter.sv
// tb_ahb_lite_bus_arbiter
// Directed scenarios for the two-master arbiter.
// A behavioural ownership model is compared against every output on each falling edge.
// Hand-computed literal checks pin the model at the key points of each scenario.
module tb_ahb_lite_bus_arbiter;

    localparam logic DEF_M  = 1'b0;
    localparam logic HI_PRI = 1'b0;
`ifdef AHB_ARB_RR_EN
    localparam logic [31:0] TIE1 = 32'd1;   // first tie with last=0 goes to M1
`else
    localparam logic [31:0] TIE1 = 32'd0;   // HIGH_PRI=0 wins every tie
`endif
    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] NONSEQ = 2'b10;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [31:0] HADDR_M0, HADDR_M1, HWDATA_M0, HWDATA_M1;
    logic [1:0]  HTRANS_M0, HTRANS_M1;
    logic        HWRITE_M0, HWRITE_M1, HMASTLOCK_M0, HMASTLOCK_M1;
    logic [2:0]  HSIZE_M0, HSIZE_M1, HBURST_M0, HBURST_M1;
    logic [3:0]  HPROT_M0, HPROT_M1;
    logic [31:0] HRDATA_M0, HRDATA_M1;
    logic        HREADY_M0, HREADY_M1, HRESP_M0, HRESP_M1;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE, HMASTLOCK, HREADY, HRESP, HMASTER;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;

    ahb_lite_bus_arbiter #(.DEFAULT_MASTER(DEF_M), .HIGH_PRI(HI_PRI)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .HADDR_M0(HADDR_M0), .HTRANS_M0(HTRANS_M0), .HWRITE_M0(HWRITE_M0), .HSIZE_M0(HSIZE_M0),
        .HBURST_M0(HBURST_M0), .HPROT_M0(HPROT_M0), .HMASTLOCK_M0(HMASTLOCK_M0), .HWDATA_M0(HWDATA_M0),
        .HRDATA_M0(HRDATA_M0), .HREADY_M0(HREADY_M0), .HRESP_M0(HRESP_M0),
        .HADDR_M1(HADDR_M1), .HTRANS_M1(HTRANS_M1), .HWRITE_M1(HWRITE_M1), .HSIZE_M1(HSIZE_M1),
        .HBURST_M1(HBURST_M1), .HPROT_M1(HPROT_M1), .HMASTLOCK_M1(HMASTLOCK_M1), .HWDATA_M1(HWDATA_M1),
        .HRDATA_M1(HRDATA_M1), .HREADY_M1(HREADY_M1), .HRESP_M1(HRESP_M1),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
        .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA), .HRDATA(HRDATA),
        .HREADY(HREADY), .HRESP(HRESP), .HMASTER(HMASTER)
    );

    always #5 HCLK = ~HCLK;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-master views of the stimulus for the model.
    logic [31:0] a_addr [2];
    logic [31:0] a_wdata [2];
    logic [1:0]  a_trans [2];
    logic [2:0]  a_size [2];
    logic [2:0]  a_burst [2];
    logic [3:0]  a_prot [2];
    logic [1:0]  a_write, a_lock, req;
    assign a_addr[0]  = HADDR_M0;   assign a_addr[1]  = HADDR_M1;
    assign a_wdata[0] = HWDATA_M0;  assign a_wdata[1] = HWDATA_M1;
    assign a_trans[0] = HTRANS_M0;  assign a_trans[1] = HTRANS_M1;
    assign a_size[0]  = HSIZE_M0;   assign a_size[1]  = HSIZE_M1;
    assign a_burst[0] = HBURST_M0;  assign a_burst[1] = HBURST_M1;
    assign a_prot[0]  = HPROT_M0;   assign a_prot[1]  = HPROT_M1;
    assign a_write = {HWRITE_M1, HWRITE_M0};
    assign a_lock  = {HMASTLOCK_M1, HMASTLOCK_M0};
    assign req     = {HTRANS_M1[1], HTRANS_M0[1]};

    // Model: the holder owns the address bus; arbitrating means one IDLE cycle before a handover.
    int m_holder = 0;
    bit m_arb    = 1'b0;
    int m_downer = 0;
    bit m_dact   = 1'b0;

    // Model update from the spec rules, sampled on the rising edge.
    always @(posedge HCLK) begin
        if (!HRESETn) begin
            m_holder <= int'(DEF_M);
            m_arb    <= 1'b0;
            m_downer <= int'(DEF_M);
            m_dact   <= 1'b0;
        end else begin
            if (HREADY) begin
                m_downer <= m_holder;
                m_dact   <= !m_arb && a_trans[m_holder][1];
            end
            if (!m_arb) begin
                if (HREADY && !req[m_holder] && !a_lock[m_holder] && req[1 - m_holder])
                    m_arb <= 1'b1;
            end else if (HREADY) begin
                m_arb <= 1'b0;
                if (req[0] && req[1]) begin
`ifdef AHB_ARB_RR_EN
                    m_holder <= 1 - m_holder;
`else
                    m_holder <= int'(HI_PRI);
`endif
                end else if (req[0]) begin
                    m_holder <= 0;
                end else if (req[1]) begin
                    m_holder <= 1;
                end
            end
        end
    end

    // Compare every output against the model on the falling edge.
    always @(negedge HCLK) begin
        if (cmp_en) begin
            chk("m_haddr", HADDR, a_addr[m_holder]);
            chk("m_htrans", {30'd0, HTRANS}, (!HRESETn || m_arb) ? 32'd0 : {30'd0, a_trans[m_holder]});
            chk("m_hwrite", {31'd0, HWRITE}, {31'd0, a_write[m_holder]});
            chk("m_hsize", {29'd0, HSIZE}, {29'd0, a_size[m_holder]});
            chk("m_hburst", {29'd0, HBURST}, {29'd0, a_burst[m_holder]});
            chk("m_hprot", {28'd0, HPROT}, {28'd0, a_prot[m_holder]});
            chk("m_hmastlock", {31'd0, HMASTLOCK}, {31'd0, a_lock[m_holder]});
            chk("m_hmaster", {31'd0, HMASTER}, m_holder);
            chk("m_hwdata", HWDATA, a_wdata[m_downer]);
            chk("m_hrdata_m0", HRDATA_M0, HRDATA);
            chk("m_hrdata_m1", HRDATA_M1, HRDATA);
            chk("m_hready_m0", {31'd0, HREADY_M0},
                {31'd0, (!m_arb && m_holder == 0) ? HREADY : !req[0]});
            chk("m_hready_m1", {31'd0, HREADY_M1},
                {31'd0, (!m_arb && m_holder == 1) ? HREADY : !req[1]});
            chk("m_hresp_m0", {31'd0, HRESP_M0}, {31'd0, (m_dact && m_downer == 0) ? HRESP : 1'b0});
            chk("m_hresp_m1", {31'd0, HRESP_M1}, {31'd0, (m_dact && m_downer == 1) ? HRESP : 1'b0});
        end
    end

    task automatic tick();
        @(posedge HCLK);
        #1;
        cyc++;
        HRDATA = 32'hA500_0000 + cyc;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic set_m0(input logic [1:0] tr, input logic [31:0] ad, input logic wr, input logic lk);
        HTRANS_M0 = tr; HADDR_M0 = ad; HWRITE_M0 = wr; HMASTLOCK_M0 = lk;
    endtask

    task automatic set_m1(input logic [1:0] tr, input logic [31:0] ad, input logic wr, input logic lk);
        HTRANS_M1 = tr; HADDR_M1 = ad; HWRITE_M1 = wr; HMASTLOCK_M1 = lk;
    endtask

    // Directed scenarios with literal expectations.
    initial begin
        HRESETn = 1'b0; HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
        set_m0(IDLE, 32'h0, 1'b0, 1'b0);
        set_m1(IDLE, 32'h0, 1'b0, 1'b0);
        HWDATA_M0 = 32'h0; HWDATA_M1 = 32'h0;
        HSIZE_M0 = 3'd2; HBURST_M0 = 3'd0; HPROT_M0 = 4'h3;
        HSIZE_M1 = 3'd1; HBURST_M1 = 3'd1; HPROT_M1 = 4'hA;

        // Reset: HTRANS forced IDLE even with a request present.
        tick(); cmp_en = 1'b1;
        set_m0(NONSEQ, 32'h5000_0000, 1'b1, 1'b0); settle();
        chk("rst_htrans", {30'd0, HTRANS}, 32'd0);
        chk("rst_hmaster", {31'd0, HMASTER}, 32'd0);

        // Scenario 1: M0 alone writes 0xDEADBEEF to 0x5000_0000.
        tick(); HRESETn = 1'b1; settle();
        chk("s1_haddr", HADDR, 32'h5000_0000);
        chk("s1_htrans", {30'd0, HTRANS}, 32'd2);
        chk("s1_hmaster", {31'd0, HMASTER}, 32'd0);
        chk("s1_hready_m1", {31'd0, HREADY_M1}, 32'd1);
        tick(); set_m0(IDLE, 32'h0, 1'b0, 1'b0); HWDATA_M0 = 32'hDEAD_BEEF; settle();
        chk("s1_hwdata", HWDATA, 32'hDEAD_BEEF);

        // Scenario 2: M0 busy back to back while M1 waits, then handover.
        tick(); set_m0(NONSEQ, 32'h1000_0000, 1'b0, 1'b0);
        set_m1(NONSEQ, 32'h2000_0010, 1'b1, 1'b0); settle();
        chk("s2_stall_t0", {31'd0, HREADY_M1}, 32'd0);
        for (int i = 1; i < 3; i++) begin
            tick(); set_m0(NONSEQ, 32'h1000_0000 + 32'(4 * i), 1'b0, 1'b0); settle();
            chk("s2_stall", {31'd0, HREADY_M1}, 32'd0);
        end
        tick(); set_m0(IDLE, 32'h0, 1'b0, 1'b0); settle();              // T+3
        chk("s2_stall_t3", {31'd0, HREADY_M1}, 32'd0);
        tick(); settle();                                                 // T+4: ARB
        chk("s2_arb_htrans", {30'd0, HTRANS}, 32'd0);
        chk("s2_arb_hready_m1", {31'd0, HREADY_M1}, 32'd0);
        tick(); settle();                                                 // T+5: OWN1
        chk("s2_own1_haddr", HADDR, 32'h2000_0010);
        chk("s2_own1_htrans", {30'd0, HTRANS}, 32'd2);
        chk("s2_own1_hmaster", {31'd0, HMASTER}, 32'd1);
        chk("s2_own1_hready_m1", {31'd0, HREADY_M1}, 32'd1);

        // Scenario 5: three wait states in M1's write data phase, M0 requesting meanwhile.
        tick(); set_m1(IDLE, 32'h2000_0010, 1'b0, 1'b0); HWDATA_M1 = 32'hCAFE_F00D;
        HREADY = 1'b0; set_m0(NONSEQ, 32'h1100_0000, 1'b0, 1'b0); settle();
        chk("s5_hwdata_w1", HWDATA, 32'hCAFE_F00D);
        chk("s5_hready_m1_w1", {31'd0, HREADY_M1}, 32'd0);
        chk("s5_hready_m0_w1", {31'd0, HREADY_M0}, 32'd0);
        tick(); HRESP = 1'b1; settle();
        chk("s5_hresp_m1", {31'd0, HRESP_M1}, 32'd1);
        chk("s5_hresp_m0", {31'd0, HRESP_M0}, 32'd0);
        tick(); settle();
        chk("s5_hmaster_w3", {31'd0, HMASTER}, 32'd1);
        chk("s5_hwdata_w3", HWDATA, 32'hCAFE_F00D);
        tick(); HREADY = 1'b1; HRESP = 1'b0; settle();
        chk("s5_hready_m1_done", {31'd0, HREADY_M1}, 32'd1);
        tick(); settle();                                                 // ARB
        chk("s5_arb_hmaster", {31'd0, HMASTER}, 32'd1);
        chk("s5_arb_htrans", {30'd0, HTRANS}, 32'd0);
        tick(); settle();                                                 // OWN0
        chk("s5_own0_haddr", HADDR, 32'h1100_0000);
        chk("s5_own0_hmaster", {31'd0, HMASTER}, 32'd0);

        // Scenario 3: ties in ARB with last=0.
        tick(); set_m0(IDLE, 32'h0, 1'b0, 1'b0); set_m1(NONSEQ, 32'h2000_0020, 1'b0, 1'b0); settle();
        tick(); set_m0(NONSEQ, 32'h1200_0000, 1'b0, 1'b0); settle();    // ARB, both request
        chk("s3_arb1_htrans", {30'd0, HTRANS}, 32'd0);
        tick(); settle();
        chk("s3_tie1_hmaster", {31'd0, HMASTER}, TIE1);
        tick();
        if (TIE1 == 32'd1) set_m1(IDLE, 32'h0, 1'b0, 1'b0);
        else               set_m0(IDLE, 32'h0, 1'b0, 1'b0);
        settle();
        tick(); set_m0(NONSEQ, 32'h1200_0000, 1'b0, 1'b0);
        set_m1(NONSEQ, 32'h2000_0020, 1'b0, 1'b0); settle();             // ARB, both request
        chk("s3_arb2_htrans", {30'd0, HTRANS}, 32'd0);

        // Scenario 4: M0 locked with IDLE gaps while M1 requests.
        tick(); set_m0(NONSEQ, 32'h1300_0000, 1'b0, 1'b1);
        set_m1(NONSEQ, 32'h2000_0030, 1'b1, 1'b0); settle();
        chk("s3_tie2_hmaster", {31'd0, HMASTER}, 32'd0);
        chk("s4_hready_m1", {31'd0, HREADY_M1}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            set_m0((i % 2 == 0) ? IDLE : NONSEQ, 32'h1300_0000 + 32'(4 * i), 1'b0, 1'b1);
            settle();
            chk("s4_lock_hmaster", {31'd0, HMASTER}, 32'd0);
            chk("s4_lock_hready_m1", {31'd0, HREADY_M1}, 32'd0);
        end
        tick(); set_m0(IDLE, 32'h0, 1'b0, 1'b0); settle();
        chk("s4_unlock_hready_m1", {31'd0, HREADY_M1}, 32'd0);
        tick(); HREADY = 1'b0; settle();                                  // ARB, held by wait
        chk("s4_arb_hmaster", {31'd0, HMASTER}, 32'd0);
        tick(); HREADY = 1'b1; settle();                                  // still ARB
        chk("s4_arb_wait_htrans", {30'd0, HTRANS}, 32'd0);
        tick(); settle();
        chk("s4_own1_hmaster", {31'd0, HMASTER}, 32'd1);
        chk("s4_own1_haddr", HADDR, 32'h2000_0030);

        // Scenario 6: reset in the middle of an M1 transfer.
        tick(); set_m1(NONSEQ, 32'h2000_0034, 1'b1, 1'b0); HWDATA_M1 = 32'h1111_2222;
        HRESETn = 1'b0; settle();
        chk("s6_rst_htrans", {30'd0, HTRANS}, 32'd0);
        chk("s6_rst_hwdata", HWDATA, 32'h1111_2222);
        tick(); HRESETn = 1'b1; settle();
        chk("s6_hmaster", {31'd0, HMASTER}, 32'd0);
        chk("s6_htrans", {30'd0, HTRANS}, 32'd0);
        chk("s6_hready_m1", {31'd0, HREADY_M1}, 32'd0);
        chk("s6_hwdata", HWDATA, 32'hDEAD_BEEF);

        // ARB with the requester withdrawn returns to the last owner.
        tick(); set_m1(IDLE, 32'h0, 1'b0, 1'b0); settle();                // ARB
        chk("nr_arb_htrans", {30'd0, HTRANS}, 32'd0);
        tick(); settle();
        chk("nr_hmaster", {31'd0, HMASTER}, 32'd0);
        chk("nr_hready_m1", {31'd0, HREADY_M1}, 32'd1);

        tick(); tick();
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
